// File: rtl/axi4_burst_master.sv
// Single-outstanding AXI4 initiator: turns one command plus a beat stream
// into one AXI4 read or write burst, then pulses done with the worst response.
module axi4_burst_master #(
    parameter int ADDR_BITS    = 32,
    parameter int DATA_BITS    = 32,
    parameter int WSTRB_BITS   = DATA_BITS / 8,
    parameter int LOGSIZE_BITS = 3,
    parameter int LEN_BITS     = 8,
    parameter int BURST_BITS   = 2,
    parameter int RESP_BITS    = 2
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_BITS-1:0]    cmd_addr,
    input  logic [LEN_BITS-1:0]     cmd_len,
    input  logic [LOGSIZE_BITS-1:0] cmd_size,
    input  logic [BURST_BITS-1:0]   cmd_burst,
    input  logic                    wd_valid,
    output logic                    wd_ready,
    input  logic [DATA_BITS-1:0]    wd_data,
    input  logic [WSTRB_BITS-1:0]   wd_strb,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [DATA_BITS-1:0]    rd_data,
    output logic                    rd_last,
    output logic                    done,
    output logic [RESP_BITS-1:0]    done_resp,
    output logic                    done_err,
    output logic [ADDR_BITS-1:0]    araddr,
    output logic                    arvalid,
    input  logic                    arready,
    output logic [LOGSIZE_BITS-1:0] arsize,
    output logic [LEN_BITS-1:0]     arlen,
    output logic [BURST_BITS-1:0]   arburst,
    input  logic [DATA_BITS-1:0]    rdata,
    input  logic                    rvalid,
    output logic                    rready,
    input  logic                    rlast,
    input  logic [RESP_BITS-1:0]    rresp,
    output logic [ADDR_BITS-1:0]    awaddr,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [LOGSIZE_BITS-1:0] awsize,
    output logic [LEN_BITS-1:0]     awlen,
    output logic [BURST_BITS-1:0]   awburst,
    output logic [DATA_BITS-1:0]    wdata,
    output logic                    wvalid,
    input  logic                    wready,
    output logic [WSTRB_BITS-1:0]   wstrb,
    output logic                    wlast,
    input  logic                    bvalid,
    output logic                    bready,
    input  logic [RESP_BITS-1:0]    bresp
);

    typedef enum logic [2:0] {
        S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_BITS-1:0]    addr_q, addr_d;
    logic [LEN_BITS-1:0]     len_q, len_d;
    logic [LOGSIZE_BITS-1:0] size_q, size_d;
    logic [BURST_BITS-1:0]   burst_q, burst_d;
    logic [LEN_BITS:0]       cnt_q, cnt_d;
    logic [RESP_BITS-1:0]    resp_q, resp_d;
    logic                    err_q, err_d;
    logic                    last_beat;

    // Extra counter bit lets len=255 reach 256 beats without wrapping.
    assign last_beat = (cnt_q == {1'b0, len_q});

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            cnt_q   <= '0;
            resp_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;
        cnt_d   = cnt_q;
        resp_d  = resp_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                    size_d  = cmd_size;
                    burst_d = cmd_burst;
                    cnt_d   = '0;
                    resp_d  = '0;
                    err_d   = 1'b0;
                    state_d = cmd_write ? S_AW : S_AR;
                end
            end
            S_AR: begin
                if (arready) state_d = S_R;
            end
            S_R: begin
                if (rvalid && rd_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (rresp > resp_q) resp_d = rresp;
                    if (last_beat) begin
                        state_d = S_DONE;
                        if (!rlast) err_d = 1'b1;
                    end else if (rlast) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_AW: begin
                if (awready) state_d = S_W;
            end
            S_W: begin
                if (wd_valid && wready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_beat) state_d = S_B;
                end
            end
            S_B: begin
                if (bvalid) begin
                    if (bresp > resp_q) resp_d = bresp;
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decode only state_q, so reset drops them at once.
    assign cmd_ready = (state_q == S_IDLE);

    assign arvalid = (state_q == S_AR);
    assign araddr  = addr_q;
    assign arlen   = len_q;
    assign arsize  = size_q;
    assign arburst = burst_q;

    assign awvalid = (state_q == S_AW);
    assign awaddr  = addr_q;
    assign awlen   = len_q;
    assign awsize  = size_q;
    assign awburst = burst_q;

    assign rready   = (state_q == S_R) & rd_ready;
    assign rd_valid = (state_q == S_R) & rvalid;
    assign rd_data  = rdata;
    assign rd_last  = (state_q == S_R) & rlast;

    assign wvalid   = (state_q == S_W) & wd_valid;
    assign wd_ready = (state_q == S_W) & wready;
    assign wdata    = wd_data;
    assign wstrb    = wd_strb;
    assign wlast    = (state_q == S_W) & last_beat;

    assign bready    = (state_q == S_B);
    assign done      = (state_q == S_DONE);
    assign done_resp = resp_q;
    assign done_err  = err_q;

endmodule

// File: tb/tb_axi4_burst_master.sv
// Bench for axi4_burst_master: randomized AXI4 slave and stream endpoints,
// expected beats/responses derived per command from the burst rules.
module tb_axi4_burst_master;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_burst;
    logic        wd_valid, wd_ready;
    logic [31:0] wd_data;
    logic [3:0]  wd_strb;
    logic        rd_valid, rd_ready, rd_last;
    logic [31:0] rd_data;
    logic        done, done_err;
    logic [1:0]  done_resp;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic        arvalid, arready, awvalid, awready;
    logic [2:0]  arsize, awsize;
    logic [7:0]  arlen, awlen;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        rvalid, rready, rlast;
    logic        wvalid, wready, wlast;
    logic [3:0]  wstrb;
    logic        bvalid, bready;

    int checks = 0;
    int errors = 0;

    int       cfg_early, cfg_rbeat, cfg_abort;
    bit       cfg_toggle, cfg_nolast, cfg_randresp, cfg_seq;
    logic [1:0] cfg_rval, cfg_bresp;

    always #5 PCLK = ~PCLK;

    axi4_burst_master dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_size(cmd_size),
        .cmd_burst(cmd_burst),
        .wd_valid(wd_valid), .wd_ready(wd_ready),
        .wd_data(wd_data), .wd_strb(wd_strb),
        .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .done_resp(done_resp), .done_err(done_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .arsize(arsize), .arlen(arlen), .arburst(arburst),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .rlast(rlast), .rresp(rresp),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .awsize(awsize), .awlen(awlen), .awburst(awburst),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic clear_drv();
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
        cmd_size = 0; cmd_burst = 0;
        wd_valid = 0; wd_data = 0; wd_strb = 0; rd_ready = 0;
        arready = 0; awready = 0; wready = 0;
        rvalid = 0; rdata = 0; rlast = 0; rresp = 0;
        bvalid = 0; bresp = 0;
    endtask

    task automatic cfg_default();
        cfg_early = -1; cfg_rbeat = -1; cfg_abort = -1;
        cfg_toggle = 0; cfg_nolast = 0; cfg_randresp = 0; cfg_seq = 0;
        cfg_rval = 0; cfg_bresp = 0;
    endtask

    // Called at posedge+1; returns at posedge+1.
    task automatic run_cmd(input bit wr, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] sz,
                           input logic [1:0] bu);
        int nb, nbs, acc_cyc, cyc, ri, wi, busy_bad, mir_bad;
        logic [31:0] rdat[$], wdat[$], gd[$];
        logic [1:0]  rr[$];
        logic [3:0]  ws[$], gs[$];
        logic        gl[$];
        logic [1:0]  exp_resp, v;
        bit exp_err, accepted, ar_ok, rdone, dseen, aborted;
        bit r_hs, w_hs, b_hs, lst;
        nb = int'(len) + 1;
        nbs = (!wr && cfg_early >= 0 && cfg_early < nb) ? cfg_early + 1 : nb;
        exp_resp = 0;
        acc_cyc = 0; cyc = 0; ri = 0; wi = 0; busy_bad = 0; mir_bad = 0;
        accepted = 0; ar_ok = 0; rdone = 0; dseen = 0; aborted = 0;
        for (int i = 0; i < nbs; i++) begin
            rdat.push_back(cfg_seq ? 32'(i + 1) : $urandom);
            if (cfg_randresp) v = 2'($urandom_range(0, 3));
            else v = (i == cfg_rbeat) ? cfg_rval : 2'd0;
            rr.push_back(v);
            if (!wr && v > exp_resp) exp_resp = v;
        end
        for (int i = 0; i < nb; i++) begin
            wdat.push_back(cfg_seq ? 32'(i + 1) : $urandom);
            ws.push_back(cfg_seq ? 4'hF : 4'($urandom_range(0, 15)));
        end
        if (wr) exp_resp = cfg_bresp;
        exp_err = !wr && (nbs < nb || cfg_nolast);

        cmd_valid = 1; cmd_write = wr; cmd_addr = addr;
        cmd_len = len; cmd_size = sz; cmd_burst = bu;
        while (!dseen && !aborted && cyc < 4000) begin
            @(negedge PCLK);
            r_hs = 0; w_hs = 0; b_hs = 0;
            if (accepted && cyc == acc_cyc + 1)
                check(wr ? "aw_after_accept" : "ar_after_accept",
                      wr ? awvalid : arvalid, 1'b1);
            if (accepted && cmd_ready) busy_bad++;
            if (wr ? arvalid : awvalid) busy_bad++;
            if (ar_ok && !rdone) begin
                if (rready !== rd_ready || rd_valid !== rvalid) mir_bad++;
            end else if (rready || rd_valid) mir_bad++;
            if (cmd_valid && cmd_ready) begin
                accepted = 1; acc_cyc = cyc;
            end
            if (arvalid && arready) begin
                ar_ok = 1;
                check("araddr", araddr, addr);
                check("arlen", arlen, len);
                check("arsize", arsize, sz);
                check("arburst", arburst, bu);
            end
            if (rvalid && rready) begin
                gd.push_back(rd_data); gl.push_back(rd_last);
                ri++; r_hs = 1;
                if (ri == nbs) rdone = 1;
            end
            if (awvalid && awready) begin
                check("awaddr", awaddr, addr);
                check("awlen", awlen, len);
                check("awsize", awsize, sz);
                check("awburst", awburst, bu);
            end
            if (wvalid && wready) begin
                gd.push_back(wdata); gs.push_back(wstrb);
                gl.push_back(wlast); wi++; w_hs = 1;
            end
            if (bvalid && bready) b_hs = 1;
            if (done) begin
                dseen = 1;
                check("done_resp", done_resp, exp_resp);
                check("done_err", done_err, exp_err);
            end
            @(posedge PCLK); #1; cyc++;
            if (accepted) cmd_valid = 0;
            arready = 1'($urandom_range(0, 1));
            awready = 1'($urandom_range(0, 1));
            wready = ($urandom_range(0, 3) != 0);
            rd_ready = cfg_toggle ? !rd_ready : ($urandom_range(0, 3) != 0);
            if (r_hs) rvalid = 0;
            if (ar_ok && ri < nbs && !rvalid && $urandom_range(0, 2) != 0) begin
                rvalid = 1; rdata = rdat[ri]; rresp = rr[ri];
                rlast = (ri == nbs - 1) && !cfg_nolast;
            end
            if (w_hs) wd_valid = 0;
            if (wr && wi < nb && !wd_valid && $urandom_range(0, 2) != 0) begin
                wd_valid = 1; wd_data = wdat[wi]; wd_strb = ws[wi];
            end
            if (b_hs) bvalid = 0;
            else if (wr && wi == nb && !bvalid && $urandom_range(0, 1) != 0) begin
                bvalid = 1; bresp = cfg_bresp;
            end
            if (wr && cfg_abort >= 0 && wi == cfg_abort) begin
                aborted = 1;
                wd_valid = 1; wd_data = wdat[wi]; wd_strb = ws[wi];
                rvalid = 1; bvalid = 1; rd_ready = 1;
                #2 PRESETn = 0;
                #1;
                check("rst_arvalid", arvalid, 1'b0);
                check("rst_awvalid", awvalid, 1'b0);
                check("rst_wvalid", wvalid, 1'b0);
                check("rst_cmd_ready", cmd_ready, 1'b1);
                check("rst_rready_bready", {rready, bready}, 2'b00);
                clear_drv();
                @(negedge PCLK); @(negedge PCLK);
                PRESETn = 1;
                @(posedge PCLK); #1;
            end
        end
        if (!aborted) begin
            check("done_seen", dseen, 1'b1);
            lst = 0;
            if (!wr) begin
                check("rbeats", gd.size(), nbs);
                for (int i = 0; i < gd.size() && i < nbs; i++) begin
                    check("rd_data", gd[i], rdat[i]);
                    lst = (i == nbs - 1) && !cfg_nolast;
                    check("rd_last", gl[i], lst);
                end
            end else begin
                check("wbeats", gd.size(), nb);
                for (int i = 0; i < gd.size() && i < nb; i++) begin
                    check("wdata", gd[i], wdat[i]);
                    check("wstrb", gs[i], ws[i]);
                    lst = (i == nb - 1);
                    check("wlast", gl[i], lst);
                end
            end
            check("busy_violations", busy_bad, 0);
            check("rd_mirror_violations", mir_bad, 0);
            @(negedge PCLK);
            check("done_one_cycle", done, 1'b0);
            check("ready_after_done", cmd_ready, 1'b1);
            @(posedge PCLK); #1;
        end
        rvalid = 0; rlast = 0; bvalid = 0; wd_valid = 0;
        cfg_default();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        bit wr;
        clear_drv();
        cfg_default();
        repeat (2) @(posedge PCLK);
        #1;
        check("reset_cmd_ready", cmd_ready, 1'b1);
        check("reset_valids", {arvalid, awvalid, wvalid, rready, bready}, 5'b0);
        check("reset_done", {done, done_resp, done_err}, 4'b0);
        check("reset_addr", {araddr, awaddr}, 64'h0);
        check("reset_len_size_burst",
              {arlen, awlen, arsize, awsize, arburst, awburst}, 26'h0);
        @(negedge PCLK);
        PRESETn = 1;
        @(posedge PCLK); #1;

        rvalid = 1; bvalid = 1; rd_ready = 1;
        @(negedge PCLK);
        check("idle_stray_r", {rready, rd_valid}, 2'b00);
        check("idle_stray_b", bready, 1'b0);
        @(posedge PCLK); #1;
        clear_drv();

        run_cmd(0, 32'h1000_0004, 8'd0, 3'd2, 2'd1);

        cfg_seq = 1;
        run_cmd(1, 32'h1000_0100, 8'd3, 3'd2, 2'd1);

        cfg_toggle = 1; cfg_seq = 1;
        run_cmd(0, 32'h1000_0200, 8'd3, 3'd2, 2'd1);

        cfg_rbeat = 2; cfg_rval = 2'd2;
        run_cmd(0, 32'h1000_0300, 8'd3, 3'd2, 2'd1);
        cfg_bresp = 2'd3;
        run_cmd(1, 32'h1000_0400, 8'd2, 3'd2, 2'd1);

        cfg_early = 1;
        run_cmd(0, 32'h1000_0500, 8'd3, 3'd2, 2'd1);
        run_cmd(0, 32'h1000_0600, 8'd3, 3'd2, 2'd2);

        cfg_nolast = 1;
        run_cmd(0, 32'h1000_0700, 8'd1, 3'd2, 2'd0);

        run_cmd(0, 32'h2000_0000, 8'd255, 3'd2, 2'd1);
        run_cmd(1, 32'h2000_1000, 8'd255, 3'd2, 2'd1);

        cfg_abort = 2;
        run_cmd(1, 32'h1000_0800, 8'd7, 3'd2, 2'd1);
        run_cmd(1, 32'h1000_0900, 8'd3, 3'd2, 2'd1);

        for (int n = 0; n < 25; n++) begin
            wr = 1'($urandom_range(0, 1));
            cfg_randresp = 1;
            cfg_bresp = 2'($urandom_range(0, 3));
            if (!wr && $urandom_range(0, 4) == 0)
                cfg_early = $urandom_range(0, 7);
            run_cmd(wr, $urandom & 32'hFFFF_FFFC, 8'($urandom_range(0, 15)),
                    3'($urandom_range(0, 2)), 2'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4_burst_master.md
Name: axi4_burst_master

Overview:
- Single-outstanding AXI4 initiator that converts a simple command/stream interface into AXI4 read and write bursts.
- It is the other end of the bus from the PLIC AXI4 responder.
- Used by the bench/DMA path to drive the PLIC register file and other AXI4 slaves in the subsystem.
- No ID, lock, cache or QoS signals; same channel subset as the PLIC AXI4 port.

Parameters:
ADDR_BITS, 32, address width
DATA_BITS, 32, data width
WSTRB_BITS, 4, DATA_BITS/8
LOGSIZE_BITS, 3, AxSIZE width
LEN_BITS, 8, AxLEN width
BURST_BITS, 2, AxBURST width
RESP_BITS, 2, xRESP width

Ports:
PCLK  in  1  clock
PRESETn  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_write  in  1  1=write burst, 0=read burst
cmd_addr  in  ADDR_BITS  start address
cmd_len  in  LEN_BITS  beats-1
cmd_size  in  LOGSIZE_BITS  bytes per beat, log2
cmd_burst  in  BURST_BITS  FIXED/INCR/WRAP, passed through
wd_valid/wd_ready  in/out  1  write-data stream handshake
wd_data  in  DATA_BITS  write beat data
wd_strb  in  WSTRB_BITS  write beat strobes
rd_valid/rd_ready  out/in  1  read-data stream handshake
rd_data  out  DATA_BITS  read beat data
rd_last  out  1  final read beat
done  out  1  one-cycle pulse at end of command
done_resp  out  RESP_BITS  worst response of the command
done_err  out  1  protocol error seen (rlast mismatch)
araddr,arvalid,arready,arsize,arlen,arburst  AXI4 AR channel, master side
rdata,rvalid,rready,rlast,rresp  AXI4 R channel, master side
awaddr,awvalid,awready,awsize,awlen,awburst  AXI4 AW channel, master side
wdata,wvalid,wready,wstrb,wlast  AXI4 W channel, master side
bvalid,bready,bresp  AXI4 B channel, master side

Behaviour:
- States: IDLE, AR, R, AW, W, B, DONE. Reset enters IDLE and clears every register.
- Output reset values: all valid/ready outputs 0 except cmd_ready=1; done=0; done_resp=0; done_err=0; all address/len/size/burst outputs 0.
- IDLE: cmd_ready=1. On cmd_valid, register the command and go to AR or AW.
- Registered fields: addr, len, size, burst, write; beat counter <= 0; resp_acc <= 0; err <= 0.
- AR/AW: arvalid/awvalid=1 from registered fields, held stable until the ready handshake.
  - AR handshake -> R; AW handshake -> W. Earliest handshake is the cycle after command acceptance.
- R: rready=rd_ready; rd_valid=rvalid; rd_data=rdata and rd_last=rlast combinationally (zero-latency pass-through).
  - Each rvalid&rready: counter++ and resp_acc <= max(resp_acc, rresp).
  - Beat with counter==len: -> DONE. err set if rlast=0 on that beat.
  - rlast on a beat with counter<len: err set, go to DONE.
- W: wvalid=wd_valid; wd_ready=wready; wdata/wstrb from the stream; wlast=(counter==len).
  - Each wvalid&wready: counter++. The last beat -> B.
  - wvalid never depends on wready.
- B: bready=1. On bvalid: resp_acc <= max(resp_acc, bresp); -> DONE.
- DONE: one cycle; done=1; done_resp=resp_acc; done_err=err; -> IDLE. Fields hold until the next command.
- Address outputs carry the start address only; the slave computes burst addresses.
- Counter is LEN_BITS+1 wide; cmd_len=255 gives 256 beats without wrap.
- cmd_size is passed through unchecked. A size larger than the data width is the caller's error.
- Single outstanding transaction: cmd_ready=0 from acceptance through DONE. A cmd_valid held high then re-accepts in the cycle after DONE.
- Unexpected rvalid/bvalid outside R/B is ignored; rready and bready stay 0 there.
- Reset mid-burst: immediate return to IDLE; all valids drop asynchronously.

Test Plan:
- Read, cmd_addr=0x10000004, len=0, INCR, against the PLIC slave -> arvalid one cycle after accept; one R beat with rd_last=1; done pulse, done_resp=0, done_err=0.
- Write burst len=3, INCR, size=2, data 0x1..0x4, strb=0xF -> four W beats; wlast only on the fourth beat; bready in B; done pulse after bvalid.
- Read len=3 with rd_ready toggling every other cycle -> rready mirrors rd_ready; exactly 4 beats forwarded in order; no beat lost or duplicated.
- Slave returns rresp=2 on beat 2 and bresp=3 on a later write -> read done_resp=2; write done_resp=3.
- Slave asserts rlast on beat 1 of a len=3 read -> DONE early with done_err=1; next command accepted normally.
- Assert PRESETn low in the middle of a W burst -> arvalid/awvalid/wvalid=0 and cmd_ready=1 immediately; a new write after release completes cleanly.
